// File: rtl/adc733_chan_acc.sv
// Per-channel windowed accumulator for the ADC733 serial receiver: sums samples per
// channel between SYNC strobes and streams a snapshot of the finished window downstream.
module adc733_chan_acc #(
  parameter int NCH   = 6,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             sync,
  input  logic             s_valid,
  input  logic             s_first,
  input  logic [15:0]      s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [2:0]       m_chan,
  output logic [31:0]      m_sum,
  output logic [CNT_W-1:0] m_cnt,
  output logic             m_last,
  output logic             err_align,
  output logic             err_ovr,
  output logic             err_sat
);

  localparam int DATA_W = 16;
  localparam int ACC_W  = DATA_W + CNT_W;
  localparam logic [2:0] LAST_CH = 3'(NCH - 1);

  typedef enum logic {ST_ACC, ST_DUMP} state_t;

  state_t state, state_nxt;
  logic [2:0] ch, tgt, ch_nxt;
  logic [2:0] out_idx, out_idx_nxt;
  logic       take_snap;

  logic signed [ACC_W-1:0] acc      [NCH];
  logic        [CNT_W-1:0] cnt      [NCH];
  logic signed [ACC_W-1:0] snap_acc [NCH];
  logic        [CNT_W-1:0] snap_cnt [NCH];

  function automatic logic cnt_full(input logic [CNT_W-1:0] c);
    return &c;
  endfunction

  function automatic logic signed [ACC_W-1:0] ext_sample(input logic [DATA_W-1:0] d);
    return {{CNT_W{d[DATA_W-1]}}, d};
  endfunction

  function automatic logic [31:0] to_sum(input logic signed [ACC_W-1:0] a);
    return {{(32-ACC_W){a[ACC_W-1]}}, a};
  endfunction

  // s_first re-aligns the frame: the sample goes to channel 0 whatever ch says.
  always_comb begin
    tgt    = s_first ? 3'd0 : ch;
    ch_nxt = (tgt == LAST_CH) ? 3'd0 : tgt + 3'd1;
  end

  always_comb begin
    state_nxt   = state;
    out_idx_nxt = out_idx;
    take_snap   = 1'b0;
    case (state)
      ST_ACC: begin
        if (sync) begin
          take_snap   = 1'b1;
          state_nxt   = ST_DUMP;
          out_idx_nxt = 3'd0;
        end
      end
      ST_DUMP: begin
        if (m_ready) begin
          if (out_idx == LAST_CH) begin
            state_nxt   = ST_ACC;
            out_idx_nxt = 3'd0;
          end else begin
            out_idx_nxt = out_idx + 3'd1;
          end
        end
      end
      default: state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state     <= ST_ACC;
      out_idx   <= 3'd0;
      ch        <= 3'd0;
      err_align <= 1'b0;
      err_ovr   <= 1'b0;
      err_sat   <= 1'b0;
    end else begin
      state   <= state_nxt;
      out_idx <= out_idx_nxt;
      if (s_valid) begin
        ch <= ch_nxt;
        if (s_first && ch != 3'd0)
          err_align <= 1'b1;
        if (!take_snap && cnt_full(cnt[tgt]))
          err_sat <= 1'b1;
      end
      if (sync && state == ST_DUMP)
        err_ovr <= 1'b1;
    end
  end

  // Snapshot sees the window before the coincident sample; that sample opens the new window.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < NCH; i++) begin
        acc[i]      <= '0;
        cnt[i]      <= '0;
        snap_acc[i] <= '0;
        snap_cnt[i] <= '0;
      end
    end else if (take_snap) begin
      for (int i = 0; i < NCH; i++) begin
        snap_acc[i] <= acc[i];
        snap_cnt[i] <= cnt[i];
        acc[i]      <= '0;
        cnt[i]      <= '0;
      end
      if (s_valid) begin
        acc[tgt] <= ext_sample(s_data);
        cnt[tgt] <= CNT_W'(1);
      end
    end else if (s_valid && !cnt_full(cnt[tgt])) begin
      acc[tgt] <= acc[tgt] + ext_sample(s_data);
      cnt[tgt] <= cnt[tgt] + CNT_W'(1);
    end
  end

  // Output word is a pure function of the frozen snapshot and out_idx, so it holds under backpressure.
  always_comb begin
    m_valid = 1'b0;
    m_chan  = 3'd0;
    m_sum   = 32'd0;
    m_cnt   = '0;
    m_last  = 1'b0;
    if (state == ST_DUMP) begin
      m_valid = 1'b1;
      m_chan  = out_idx;
      m_sum   = to_sum(snap_acc[out_idx]);
      m_cnt   = snap_cnt[out_idx];
      m_last  = (out_idx == LAST_CH);
    end
  end

endmodule

// File: doc/adc733_chan_acc.md
ADC733_CHAN_ACC -- requirements
Module: adc733_chan_acc

Interface
REQ-001 Parameter NCH, default 6: channels per frame from the ADC serial receiver.
REQ-002 Parameter CNT_W, default 10: per-channel sample-count width; max count 2**CNT_W-1.
REQ-003 Port clk, input, 1: single system clock (12 MHz nominal); all logic on rising edge.
REQ-004 Port rst_l, input, 1: asynchronous, active-low reset.
REQ-005 Port sync, input, 1: one-clk window-boundary strobe (same SYNC as the ADC wrapper).
REQ-006 Port s_valid, input, 1: one-clk strobe, new sample from the upstream ADC serial receiver.
REQ-007 Port s_first, input, 1: qualifies s_valid; sample belongs to channel 0.
REQ-008 Port s_data, input, 16: two's-complement sample.
REQ-009 Port m_valid, output, 1: output word valid.
REQ-010 Port m_ready, input, 1: downstream accepts word when m_valid and m_ready both high.
REQ-011 Port m_chan, output, 3: channel index of output word.
REQ-012 Port m_sum, output, 32: signed sum of window samples, sign-extended.
REQ-013 Port m_cnt, output, CNT_W: number of samples summed.
REQ-014 Port m_last, output, 1: high on word with m_chan = NCH-1.
REQ-015 Port err_align, err_ovr, err_sat, outputs, 1 each: sticky error flags.

Function
REQ-016 Internal channel index ch increments on each s_valid, wraps NCH-1 -> 0.
REQ-017 s_valid with s_first shall force the sample to channel 0 and next ch to 1; if ch was not 0, err_align shall set.
REQ-018 Per channel: acc (signed, 16+CNT_W bits) += s_data, cnt += 1, on s_valid for that channel.
REQ-019 If cnt of target channel equals 2**CNT_W-1, the sample is dropped (acc, cnt unchanged) and err_sat sets.
REQ-020 State machine: ACC (accumulating, output idle) and DUMP (streaming snapshot); accumulation continues in both states.
REQ-021 sync in ACC: on that edge, all acc/cnt copied to snapshot bank, acc/cnt cleared, state -> DUMP, out index = 0.
REQ-022 sync coincident with s_valid in ACC: snapshot excludes the sample; new window acc = s_data, cnt = 1 for that channel.
REQ-023 DUMP: m_valid = 1 from the cycle after the sync edge; m_chan = out index; m_sum/m_cnt from snapshot.
REQ-024 Word transfer on m_valid & m_ready; out index increments; transfer with m_last returns state to ACC, m_valid = 0 next cycle.
REQ-025 m_chan, m_sum, m_cnt, m_last shall hold stable while m_valid & !m_ready.
REQ-026 sync in DUMP: ignored (no snapshot, no clear, window extends), err_ovr sets.
REQ-027 Channels with no samples in window output m_sum = 0, m_cnt = 0.
REQ-028 Minimum stream length NCH cycles with m_ready held high.
REQ-029 Error flags clear only by reset.

Reset
REQ-030 rst_l low asynchronously: state ACC, ch = 0, all acc/cnt/snapshot = 0, m_valid = 0, m_chan = 0, m_sum = 0, m_cnt = 0, m_last = 0, err flags = 0.
REQ-031 Reset during DUMP abandons the stream; after release the first sync starts a fresh window.

Verification
REQ-032 Samples 100,200,...,600 (s_first on first) x3 frames, sync, m_ready=1 -> 6 words, ch k sum = 3*100*(k+1), cnt = 3, m_last on ch 5 only.
REQ-033 Negative samples: ch 0 gets -32768 twice -> m_sum = 0xFFFF0000, m_cnt = 2.
REQ-034 m_ready low 5 cycles during DUMP -> outputs frozen; second sync inside DUMP -> err_ovr = 1, next dump covers extended window.
REQ-035 s_first on 4th sample of a frame -> err_align = 1, that sample lands in ch 0, next in ch 1.
REQ-036 CNT_W=2, 4 samples to ch 0 in a window -> m_cnt = 3, 4th dropped, err_sat = 1.
REQ-037 sync and s_valid (ch 2, value 7) same cycle -> snapshot ch 2 excludes 7; next window ch 2 sum = 7, cnt = 1; rst_l pulse mid-DUMP -> all outputs 0 immediately.
